imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory word-address width (256 words).
REQ-002 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  in  1  begin a load session; sampled in IDLE only.
REQ-005 SHALL have port base_addr  in  ADDR_W  first word address of the session; captured at start.
REQ-006 SHALL have port word_count  in  ADDR_W  number of words to load; captured at start; 0 = no words.
REQ-007 SHALL have port abort  in  1  cancel the session.
REQ-008 SHALL have port in_valid  in  1  byte-stream source has a byte.
REQ-009 SHALL have port in_byte  in  8  stream byte.
REQ-010 SHALL have port in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid and in_ready are both 1.
REQ-011 SHALL have port wr_en  out  1  one-cycle instruction-memory write strobe.
REQ-012 SHALL have port wr_addr  out  ADDR_W  word address for the write.
REQ-013 SHALL have port wr_data  out  32  instruction word for the write.
REQ-014 SHALL have port busy  out  1  session in progress; drives the processor's reset hold.
REQ-015 SHALL have port done  out  1  one-cycle pulse at normal session end.

Function
REQ-016 SHALL implement FSM states IDLE, RECV, WRITE, DONE; all outputs registered.
REQ-017 IDLE: start=1, word_count!=0 -> RECV; capture addr=base_addr, words_left=word_count, byte_idx=0.
REQ-018 IDLE: start=1, word_count=0 -> DONE with no write.
REQ-019 start SHALL be ignored in every state except IDLE.
REQ-020 RECV: in_ready=1; each transfer shifts in_byte into the word, big-endian: the first byte lands in bits 31:24 and the fourth byte in bits 7:0.
REQ-021 RECV: in_valid=0 cycles SHALL hold all state; there is no timeout.
REQ-022 The 4th transfer of a word SHALL move the FSM to WRITE; in_ready SHALL be 0 in the following cycle.
REQ-023 WRITE: wr_en=1 for exactly one cycle, with wr_addr=addr and wr_data=the assembled word. This cycle is the cycle after the 4th transfer (latency 1).
REQ-024 After WRITE: addr increments modulo 2^ADDR_W, so all-ones wraps to 0, and words_left decrements. words_left=0 -> DONE; otherwise -> RECV with byte_idx=0.
REQ-025 DONE: done=1 for one cycle, then -> IDLE.
REQ-026 busy SHALL be 1 in RECV and WRITE and 0 in IDLE and DONE.
REQ-027 wr_en and in_ready SHALL never both be 1.
REQ-028 abort=1 in RECV or WRITE SHALL force IDLE at the next edge. No wr_en is issued in that edge's following cycle, no done pulse is issued, and the partial word is discarded.
REQ-029 abort and the 4th-byte transfer in the same cycle: abort wins, and no write occurs.
REQ-030 Outside WRITE: wr_addr and wr_data SHALL hold their last values, and wr_en=0.

Reset
REQ-031 Reset SHALL asynchronously force state=IDLE, and in_ready, wr_en, busy and done to 0.
REQ-032 Reset SHALL asynchronously clear wr_addr, wr_data, addr, words_left and byte_idx to 0.
REQ-033 Reset mid-session SHALL discard the session, and no write SHALL be issued afterwards.

Structure
REQ-034 Package imem_loader_pkg SHALL hold the FSM state encoding and the constant BYTES_PER_WORD=4.
REQ-035 A sub-module byte_assembler SHALL hold the 32-bit shift register and the 2-bit byte counter. It provides inputs shift_en and clear, and outputs word and word_full.

Verification
REQ-036 base_addr=0, word_count=2, bytes 00 00 00 20, 00 00 00 22 streamed back-to-back -> two writes:
- wr_addr 0, wr_data 0x00000020;
- wr_addr 1, wr_data 0x00000022;
- each write 1 cycle after its 4th byte;
- then a done pulse.
REQ-037 Same load with in_valid toggling every other cycle -> identical writes and data; in_ready stays 1 through the gaps.
REQ-038 base_addr=0xFF, word_count=2 -> writes to address 0xFF and then 0x00.
REQ-039 word_count=0, start=1 -> done pulse 1 cycle later; no wr_en; busy stays 0.
REQ-040 abort asserted with the 3rd byte; reset asserted asynchronously mid-word in a second run -> in both cases no wr_en and no done, and the FSM is in IDLE. A following full load writes correctly from byte_idx 0.
REQ-041 start pulsed during RECV -> ignored: captured addr and count are unchanged, and the write sequence is unaffected.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared definitions for the instruction-memory loader: the loader FSM state
//   encoding and the byte/word geometry of the incoming stream.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    // Stream bytes per 32-bit instruction word.
    localparam int BYTES_PER_WORD = 4;

    // Width of the byte-within-word counter.
    localparam int BYTE_IDX_W = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// -----------------------------------------------------------------------------
// byte_assembler
//   Packs stream bytes into a 32-bit word, big-endian: the first byte ends up
//   in bits 31:24 and the last byte in bits 7:0.
//
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high reset
//   shift_en  : shift in_byte into the low end of the word this cycle
//   clear     : discard the partial word and restart at byte 0 (wins over shift)
//   in_byte   : byte to shift in
//   word      : current contents of the shift register
//   word_full : this cycle's shift is the last byte of a word; the complete
//               word is {word[23:0], in_byte}
// -----------------------------------------------------------------------------
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        shift_en,
    input  logic        clear,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_full
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    logic [BYTE_IDX_W-1:0] byte_idx;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (shift_en) begin
            word     <= {word[23:0], in_byte};
            byte_idx <= byte_idx + BYTE_IDX_W'(1);
        end
    end

    // Flagged combinationally so the loader can latch the finished word on the
    // same edge that accepts the last byte (one-cycle write latency).
    assign word_full = shift_en && (byte_idx == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Loads a block of 32-bit instructions from a valid/ready byte stream into
//   instruction memory. A session is started from IDLE with a base word
//   address and a word count; every four accepted bytes form one big-endian
//   word that is written with a single-cycle wr_en strobe. busy holds the
//   processor in reset while a session runs; done pulses at normal completion.
//
// Ports
//   clk, reset   : clock (rising edge) and asynchronous active-high reset
//   start        : begin a session (sampled in IDLE only)
//   base_addr    : first word address, captured at start
//   word_count   : number of words, captured at start; 0 finishes immediately
//   abort        : cancel a running session, discarding any partial word
//   in_valid     : stream byte available
//   in_byte      : stream byte
//   in_ready     : loader accepts a byte this cycle
//   wr_en        : one-cycle instruction-memory write strobe
//   wr_addr      : write word address (holds its last value between writes)
//   wr_data      : write data (holds its last value between writes)
//   busy         : session in progress (RECV or WRITE)
//   done         : one-cycle pulse at normal session end
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] words_left;

    logic              shift_en;
    logic              clear;
    logic [31:0]       word;
    logic              word_full;

    // A byte is taken only in RECV; an abort in the same cycle cancels it, so
    // an aborted 4th byte never reaches WRITE.
    assign shift_en = (state == RECV) && in_valid && !abort;

    // Restart byte assembly at the beginning of a session, after each word is
    // handed off, and whenever a session is aborted mid-word.
    assign clear = ((state == IDLE) && start) ||
                   (state == WRITE) ||
                   ((state == RECV) && abort);

    byte_assembler u_byte_assembler (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (shift_en),
        .clear     (clear),
        .in_byte   (in_byte),
        .word      (word),
        .word_full (word_full)
    );

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (word_count == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (word_full) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (words_left == ADDR_W'(1)) begin
                    next_state = DONE;
                end else begin
                    next_state = RECV;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered outputs, decoded from the state being entered so that each
    // output is valid for exactly the cycle spent in that state.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            in_ready <= (next_state == RECV);
            wr_en    <= (next_state == WRITE);
            busy     <= (next_state == RECV) || (next_state == WRITE);
            done     <= (next_state == DONE);
            if (word_full) begin
                wr_addr <= addr;
                wr_data <= (word << 8) | 32'(in_byte);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Session address / remaining-word bookkeeping
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr       <= '0;
            words_left <= '0;
        end else if ((state == IDLE) && start) begin
            addr       <= base_addr;
            words_left <= word_count;
        end else if ((state == WRITE) && !abort) begin
            // Address wraps modulo 2^ADDR_W.
            addr       <= addr + ADDR_W'(1);
            words_left <= words_left - ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed self-checking bench for imem_loader. Inputs change 1 time unit
//   after the rising edge; outputs are sampled on the falling edge by a monitor
//   that logs writes, done pulses, busy cycles and write latency.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] word_count;
    logic              abort;
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- monitor ----------------
    int          cyc = 0;
    int          last_xfer_cyc = 0;
    int          wr_count = 0;
    int          done_count = 0;
    int          done_cyc = 0;
    int          busy_cycles = 0;
    int          lat_bad = 0;
    int          overlap = 0;
    logic [31:0] wa [0:15];
    logic [31:0] wd [0:15];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (in_valid && in_ready) last_xfer_cyc <= cyc;
        if (wr_en) begin
            if (wr_count < 16) begin
                wa[wr_count] <= 32'(wr_addr);
                wd[wr_count] <= wr_data;
            end
            wr_count <= wr_count + 1;
            if (cyc - last_xfer_cyc != 1) lat_bad <= lat_bad + 1;
        end
        if (wr_en && in_ready) overlap <= overlap + 1;
        if (done) begin
            done_count <= done_count + 1;
            done_cyc   <= cyc;
        end
        if (busy) busy_cycles <= busy_cycles + 1;
    end

    // ---------------- stimulus helpers ----------------
    int start_cyc = 0;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [7:0] b, input logic [7:0] n);
        start      = 1'b1;
        base_addr  = b;
        word_count = n;
        start_cyc  = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Present one byte (optionally with abort) until it is accepted, then
    // idle in_valid for 'gap' cycles. Returns 1 time unit after an edge.
    int gap_bad = 0;
    task automatic send_byte(input logic [7:0] b, input int gap, input logic with_abort);
        bit got = 0;
        in_valid = 1'b1;
        in_byte  = b;
        abort    = with_abort;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) check("xfer_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        for (int g = 0; g < gap; g++) begin
            if (!in_ready && dut.wr_en == 1'b0) gap_bad++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(t[31:24], gap, 1'b0);
            t = t << 8;
        end
    endtask

    task automatic wait_done(input int base);
        bit got = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (done_count != base) begin
                got = 1;
                break;
            end
        end
        #1;
        if (!got) check("done_timeout", 32'd0, 32'd1);
    endtask

    int wb, db, bb;

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        abort = 1'b0; in_valid = 1'b0; in_byte = '0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wr_en",    32'(wr_en),    32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_wr_addr",  32'(wr_addr),  32'd0);
        check("rst_wr_data",  wr_data,       32'd0);
        #2 reset = 1'b0;
        idle(1);

        // ---- two words back-to-back from address 0 ----
        wb = wr_count; db = done_count;
        start_load(8'h00, 8'd2);
        check("b2b_busy", 32'(busy), 32'd1);
        send_word(32'h0000_0020, 0);
        send_word(32'h0000_0022, 0);
        wait_done(db);
        idle(3);
        check("b2b_nwr",   32'(wr_count - wb), 32'd2);
        check("b2b_addr0", wa[wb],   32'h00);
        check("b2b_data0", wd[wb],   32'h0000_0020);
        check("b2b_addr1", wa[wb+1], 32'h01);
        check("b2b_data1", wd[wb+1], 32'h0000_0022);
        check("b2b_done",  32'(done_count - db), 32'd1);
        check("b2b_idle_busy", 32'(busy), 32'd0);
        check("b2b_hold_addr", 32'(wr_addr), 32'h01);
        check("b2b_hold_data", wr_data, 32'h0000_0022);

        // ---- same load with in_valid idle every other cycle ----
        wb = wr_count; db = done_count; gap_bad = 0;
        start_load(8'h00, 8'd2);
        send_word(32'h0000_0020, 1);
        send_word(32'h0000_0022, 1);
        wait_done(db);
        idle(2);
        check("gap_nwr",   32'(wr_count - wb), 32'd2);
        check("gap_addr0", wa[wb],   32'h00);
        check("gap_data0", wd[wb],   32'h0000_0020);
        check("gap_addr1", wa[wb+1], 32'h01);
        check("gap_data1", wd[wb+1], 32'h0000_0022);
        check("gap_ready_held", 32'(gap_bad), 32'd0);

        // ---- address wrap from 0xFF, big-endian byte order ----
        wb = wr_count; db = done_count;
        start_load(8'hFF, 8'd2);
        send_word(32'h1122_3344, 0);
        send_word(32'hA5B6_C7D8, 0);
        wait_done(db);
        idle(2);
        check("wrap_nwr",   32'(wr_count - wb), 32'd2);
        check("wrap_addr0", wa[wb],   32'hFF);
        check("wrap_data0", wd[wb],   32'h1122_3344);
        check("wrap_addr1", wa[wb+1], 32'h00);
        check("wrap_data1", wd[wb+1], 32'hA5B6_C7D8);

        // ---- zero-word session ----
        wb = wr_count; db = done_count; bb = busy_cycles;
        start_load(8'h12, 8'd0);
        wait_done(db);
        idle(3);
        check("zero_done_lat", 32'(done_cyc - start_cyc), 32'd1);
        check("zero_done_cnt", 32'(done_count - db), 32'd1);
        check("zero_nwr",      32'(wr_count - wb), 32'd0);
        check("zero_busy",     32'(busy_cycles - bb), 32'd0);

        // ---- abort with the 3rd byte ----
        wb = wr_count; db = done_count;
        start_load(8'h10, 8'd1);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        send_byte(8'h33, 0, 1'b1);
        check("ab3_busy",  32'(busy),     32'd0);
        check("ab3_ready", 32'(in_ready), 32'd0);
        idle(6);
        check("ab3_nwr",  32'(wr_count - wb),   32'd0);
        check("ab3_done", 32'(done_count - db), 32'd0);

        // ---- abort together with the 4th byte ----
        wb = wr_count; db = done_count;
        start_load(8'h18, 8'd1);
        send_byte(8'h44, 0, 1'b0);
        send_byte(8'h55, 0, 1'b0);
        send_byte(8'h66, 0, 1'b0);
        send_byte(8'h77, 0, 1'b1);
        idle(6);
        check("ab4_nwr",   32'(wr_count - wb),   32'd0);
        check("ab4_done",  32'(done_count - db), 32'd0);
        check("ab4_ready", 32'(in_ready),        32'd0);

        // ---- asynchronous reset mid-word ----
        wb = wr_count; db = done_count;
        start_load(8'h20, 8'd1);
        send_byte(8'h99, 0, 1'b0);
        send_byte(8'h88, 0, 1'b0);
        #3 reset = 1'b1;
        #1;
        check("arst_busy",    32'(busy),     32'd0);
        check("arst_ready",   32'(in_ready), 32'd0);
        check("arst_wr_data", wr_data,       32'd0);
        #2 reset = 1'b0;
        idle(6);
        check("arst_nwr",  32'(wr_count - wb),   32'd0);
        check("arst_done", 32'(done_count - db), 32'd0);

        // ---- clean load afterwards starts at byte 0 ----
        wb = wr_count; db = done_count;
        start_load(8'h30, 8'd1);
        send_word(32'hDEAD_BEEF, 0);
        wait_done(db);
        idle(2);
        check("post_nwr",  32'(wr_count - wb), 32'd1);
        check("post_addr", wa[wb], 32'h30);
        check("post_data", wd[wb], 32'hDEAD_BEEF);

        // ---- start pulsed during RECV is ignored ----
        wb = wr_count; db = done_count;
        start_load(8'h40, 8'd2);
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        start = 1'b1; base_addr = 8'h80; word_count = 8'd5;
        idle(1);
        start = 1'b0;
        send_byte(8'h03, 0, 1'b0);
        send_byte(8'h04, 0, 1'b0);
        send_word(32'h0506_0708, 0);
        wait_done(db);
        idle(3);
        check("ign_nwr",   32'(wr_count - wb), 32'd2);
        check("ign_addr0", wa[wb],   32'h40);
        check("ign_data0", wd[wb],   32'h0102_0304);
        check("ign_addr1", wa[wb+1], 32'h41);
        check("ign_data1", wd[wb+1], 32'h0506_0708);
        check("ign_done",  32'(done_count - db), 32'd1);

        // ---- global properties over the whole run ----
        check("write_latency", 32'(lat_bad), 32'd0);
        check("wr_en_ready_overlap", 32'(overlap), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
